// File: rtl/atari_video_capture.sv
// TIA video stream capture into a double-buffered frame buffer of 6-bit palette indices.
// Optional per-frame line / per-line pixel statistics are enabled with `define ATARI_VIDEO_STATS_EN.
module atari_video_capture #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 192,
  parameter int ADDR_W   = 15
) (
  input  logic              CCLK,
  input  logic              RES_N,
  input  logic              ENABLE,
  input  logic              HSYNC,
  input  logic              HBLANK,
  input  logic              VSYNC,
  input  logic              VBLANK,
  input  logic [3:0]        COL,
  input  logic [1:0]        LUM,
  output logic              FB_WE,
  output logic [ADDR_W:0]   FB_ADDR,
  output logic [5:0]        FB_DATA,
  output logic              DISP_BANK,
  output logic              FRAME_DONE,
  output logic              ABORT,
  output logic [8:0]        LINE_CNT,
  output logic [7:0]        PIX_CNT
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {WAIT_VS, SYNC, BLANK, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic              hb_s1, vb_s1, vs_s1;
  logic              hb_s2, vb_s2, vs_s2;
  logic [5:0]        pix_s1;
  logic              hb_rise, vb_rise, vs_rise, vs_fall, pixel;

  logic              arm, wr_bank;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] base;

  logic              complete, abort_ev, wr, line_adv;

  // Blank stages reset to the blanking level so leaving reset never looks like a pixel or a blank edge.
  always_ff @(posedge CCLK or negedge RES_N) begin
    if (!RES_N) begin
      hb_s1  <= 1'b1;
      vb_s1  <= 1'b1;
      vs_s1  <= 1'b0;
      hb_s2  <= 1'b1;
      vb_s2  <= 1'b1;
      vs_s2  <= 1'b0;
      pix_s1 <= '0;
    end else begin
      hb_s1  <= HBLANK;
      vb_s1  <= VBLANK;
      vs_s1  <= VSYNC;
      hb_s2  <= hb_s1;
      vb_s2  <= vb_s1;
      vs_s2  <= vs_s1;
      pix_s1 <= {COL, LUM};
    end
  end

  assign hb_rise = hb_s1 & ~hb_s2;
  assign vb_rise = vb_s1 & ~vb_s2;
  assign vs_rise = vs_s1 & ~vs_s2;
  assign vs_fall = ~vs_s1 & vs_s2;
  assign pixel   = ~hb_s1 & ~vb_s1;

  always_ff @(posedge CCLK or negedge RES_N) begin
    if (!RES_N) state <= WAIT_VS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VS: if (vs_s1) state_nxt = SYNC;
      SYNC:    if (vs_fall) state_nxt = BLANK;
      BLANK: begin
        if (!arm)        state_nxt = WAIT_VS;
        else if (!vb_s1) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (complete)     state_nxt = DONE;
        else if (vs_rise) state_nxt = SYNC;
      end
      DONE:    if (vs_s1) state_nxt = SYNC;
      default: state_nxt = WAIT_VS;
    endcase
  end

  // Completion outranks an abort arriving on the same cycle.
  always_comb begin
    complete = 1'b0;
    abort_ev = 1'b0;
    wr       = 1'b0;
    line_adv = 1'b0;
    if (state == ACTIVE) begin
      line_adv = hb_rise && (x != '0);
      complete = vb_rise || (line_adv && (y == YW'(V_ACTIVE - 1)));
      abort_ev = vs_rise && !complete;
      wr       = pixel && !vs_rise && (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
    end
  end

  // The running base keeps y*H_ACTIVE without a multiplier.
  always_ff @(posedge CCLK or negedge RES_N) begin
    if (!RES_N) begin
      arm        <= 1'b0;
      wr_bank    <= 1'b0;
      x          <= '0;
      y          <= '0;
      base       <= '0;
      FB_WE      <= 1'b0;
      FB_ADDR    <= '0;
      FB_DATA    <= '0;
      DISP_BANK  <= 1'b0;
      FRAME_DONE <= 1'b0;
      ABORT      <= 1'b0;
    end else begin
      FB_WE      <= wr;
      FRAME_DONE <= complete;
      ABORT      <= abort_ev;
      if (state == SYNC && vs_fall) begin
        arm  <= ENABLE;
        x    <= '0;
        y    <= '0;
        base <= '0;
      end
      if (state == ACTIVE) begin
        if (hb_rise) begin
          x <= '0;
          if (line_adv) begin
            y    <= y + YW'(1);
            base <= base + ADDR_W'(H_ACTIVE);
          end
        end else if (wr) begin
          x <= x + XW'(1);
        end
      end
      if (wr) begin
        FB_ADDR <= {wr_bank, base + ADDR_W'(x)};
        FB_DATA <= pix_s1;
      end
      if (complete) begin
        DISP_BANK <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
    end
  end

`ifdef ATARI_VIDEO_STATS_EN
  logic       hs_s1, hs_s2, hs_rise;
  logic [8:0] hs_cnt;
  logic [7:0] px_cnt;

  assign hs_rise = hs_s1 & ~hs_s2;

  // Statistics run in every state and ignore ENABLE.
  always_ff @(posedge CCLK or negedge RES_N) begin
    if (!RES_N) begin
      hs_s1    <= 1'b0;
      hs_s2    <= 1'b0;
      hs_cnt   <= '0;
      px_cnt   <= '0;
      LINE_CNT <= '0;
      PIX_CNT  <= '0;
    end else begin
      hs_s1 <= HSYNC;
      hs_s2 <= hs_s1;
      if (vs_fall) begin
        LINE_CNT <= hs_cnt;
        hs_cnt   <= {8'd0, hs_rise};
      end else if (hs_rise && hs_cnt != 9'd511) begin
        hs_cnt <= hs_cnt + 9'd1;
      end
      if (hb_rise) begin
        PIX_CNT <= px_cnt;
        px_cnt  <= '0;
      end else if (pixel && px_cnt != 8'd255) begin
        px_cnt <= px_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_hsync;
  assign unused_hsync = HSYNC;
  assign LINE_CNT     = '0;
  assign PIX_CNT      = '0;
`endif

endmodule

// File: tb/tb_atari_video_capture.sv
// Randomized line-level stimulus for atari_video_capture, checked against a frame/line/pixel model.
module tb_atari_video_capture;

  localparam int H = 160;
  localparam int V = 192;

  logic        CCLK = 1'b0;
  logic        RES_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        HSYNC = 1'b0;
  logic        HBLANK = 1'b1;
  logic        VSYNC = 1'b0;
  logic        VBLANK = 1'b1;
  logic [3:0]  COL = '0;
  logic [1:0]  LUM = '0;
  logic        FB_WE;
  logic [15:0] FB_ADDR;
  logic [5:0]  FB_DATA;
  logic        DISP_BANK;
  logic        FRAME_DONE;
  logic        ABORT;
  logic [8:0]  LINE_CNT;
  logic [7:0]  PIX_CNT;

  atari_video_capture dut (
    .CCLK(CCLK), .RES_N(RES_N), .ENABLE(ENABLE),
    .HSYNC(HSYNC), .HBLANK(HBLANK), .VSYNC(VSYNC), .VBLANK(VBLANK),
    .COL(COL), .LUM(LUM),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA),
    .DISP_BANK(DISP_BANK), .FRAME_DONE(FRAME_DONE), .ABORT(ABORT),
    .LINE_CNT(LINE_CNT), .PIX_CNT(PIX_CNT)
  );

  always #5 CCLK = ~CCLK;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int done_seen = 0;
  int abort_seen = 0;
  int first_we_cyc = -1;
  int first_pix_cyc = -1;
  bit mark_first = 0;
  bit en = 0;
  logic [21:0] exp_q[$];

  bit m_cap = 0, m_bank = 0, m_disp = 0;
  bit m_prev_vs = 0, m_prev_vb = 1, m_prev_hb = 1;
  int m_x = 0, m_y = 0, m_done = 0, m_abort = 0;
  int m_hs = 0, m_line_exp = 0, m_pix = 0, m_pix_exp = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  always @(posedge CCLK) cyc_n <= cyc_n + 1;

  // Every write must match the oldest outstanding expected pixel.
  always @(negedge CCLK) begin
    if (RES_N) begin
      if (FB_WE) begin
        if (first_we_cyc < 0) first_we_cyc = cyc_n;
        if (exp_q.size() == 0) checkOutput("unexpected_we", {31'd0, FB_WE}, 32'd0);
        else checkOutput("fb_write", {10'd0, FB_ADDR, FB_DATA}, {10'd0, exp_q.pop_front()});
      end
      if (FRAME_DONE) done_seen++;
      if (ABORT) abort_seen++;
    end
  end

  task automatic drive(input bit hs, input bit hb, input bit vs, input bit vb, input logic [5:0] px);
    @(negedge CCLK);
    HSYNC = hs; HBLANK = hb; VSYNC = vs; VBLANK = vb;
    COL = px[5:2]; LUM = px[1:0]; ENABLE = en;
  endtask

  task automatic complete_frame();
    m_done++;
    m_disp = m_bank;
    m_bank = ~m_bank;
    m_cap = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cap = 0; m_bank = 0; m_disp = 0;
    m_hs = 0; m_line_exp = 0; m_pix = 0; m_pix_exp = 0;
    m_prev_vs = 0;
  endtask

  // One scan line: 4 blanking cycles carrying a 2-cycle HSYNC, then npix cycles with HBLANK low.
  task automatic applyStimulus(input bit vs, input bit vb, input int npix, input bit fixed, input int rst_at);
    logic [5:0] px;
    bit in_rst = 0;
    if (!m_prev_hb) begin
      if (m_cap && m_x != 0) begin
        m_y++;
        if (m_y == V) complete_frame();
      end
      m_x = 0;
      m_pix_exp = (m_pix > 255) ? 255 : m_pix;
      m_pix = 0;
    end
    if (vb && !m_prev_vb && m_cap) complete_frame();
    if (vs && !m_prev_vs && m_cap) begin
      m_abort++;
      m_cap = 0;
    end
    if (!vs && m_prev_vs) begin
      m_line_exp = (m_hs > 511) ? 511 : m_hs;
      m_hs = 0;
      m_cap = en;
      m_x = 0;
      m_y = 0;
    end
    m_hs++;
    m_prev_vs = vs;
    m_prev_vb = vb;
    drive(0, 1, vs, vb, 6'd0);
    drive(1, 1, vs, vb, 6'd0);
    drive(1, 1, vs, vb, 6'd0);
    drive(0, 1, vs, vb, 6'd0);
    for (int i = 0; i < npix; i++) begin
      px = fixed ? 6'h29 : 6'($urandom);
      drive(0, 0, vs, vb, px);
      if (in_rst) begin
        RES_N = 1'b1;
        in_rst = 0;
      end
      if (i == rst_at) begin
        #2 RES_N = 1'b0;
        #1;
        checkOutput("rst_fb_we", {31'd0, FB_WE}, 32'd0);
        checkOutput("rst_disp_bank", {31'd0, DISP_BANK}, 32'd0);
        model_reset();
        in_rst = 1;
      end else if (!vb) begin
        m_pix++;
        if (m_cap && m_x < H) begin
          if (mark_first) begin
            first_pix_cyc = cyc_n;
            mark_first = 0;
          end
          exp_q.push_back({m_bank, 15'(m_y * H + m_x), px});
          m_x++;
        end
      end
    end
    m_prev_hb = (npix > 0) ? 1'b0 : 1'b1;
  endtask

  task automatic vsync_lines(input bit first_vb);
    applyStimulus(1, first_vb, 4, 0, -1);
    applyStimulus(1, 1, 4, 0, -1);
    applyStimulus(1, 1, 4, 0, -1);
  endtask

  task automatic blank_lines(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 4, 0, -1);
  endtask

  task automatic vis_lines(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, int'($urandom_range(hi, lo)), 0, -1);
  endtask

  task automatic stats_check();
`ifdef ATARI_VIDEO_STATS_EN
    checkOutput("line_cnt", {23'd0, LINE_CNT}, m_line_exp);
    checkOutput("pix_cnt", {24'd0, PIX_CNT}, m_pix_exp);
`else
    checkOutput("line_cnt_tied", {23'd0, LINE_CNT}, 32'd0);
    checkOutput("pix_cnt_tied", {24'd0, PIX_CNT}, 32'd0);
`endif
  endtask

  task automatic frame_checks();
    checkOutput("writes_pending", exp_q.size(), 32'd0);
    checkOutput("frame_done_cnt", done_seen, m_done);
    checkOutput("abort_cnt", abort_seen, m_abort);
    checkOutput("disp_bank", {31'd0, DISP_BANK}, {31'd0, m_disp});
    stats_check();
  endtask

  initial begin
    repeat (3) @(negedge CCLK);
    checkOutput("rst_fb_we", {31'd0, FB_WE}, 32'd0);
    checkOutput("rst_fb_addr", {16'd0, FB_ADDR}, 32'd0);
    checkOutput("rst_fb_data", {26'd0, FB_DATA}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, FRAME_DONE}, 32'd0);
    checkOutput("rst_abort", {31'd0, ABORT}, 32'd0);
    checkOutput("rst_disp_bank", {31'd0, DISP_BANK}, 32'd0);
    stats_check();
    RES_N = 1'b1;
    en = 1;
    blank_lines(2);

    // Full frame of constant colour; the 193rd line falls after completion and is dropped.
    vsync_lines(1);
    blank_lines(37);
    mark_first = 1;
    for (int i = 0; i < V + 1; i++) applyStimulus(0, 0, H, 1, -1);
    blank_lines(4);
    frame_checks();
    checkOutput("first_pixel_latency", first_we_cyc - first_pix_cyc, 32'd2);

    // Overlong lines, an empty line and a saturating pixel count, written into bank 1.
    vsync_lines(1);
    blank_lines(3);
    applyStimulus(0, 0, 170, 0, -1);
    applyStimulus(0, 0, 0, 0, -1);
    stats_check();
    applyStimulus(0, 0, 260, 0, -1);
    applyStimulus(0, 0, 10, 0, -1);
    stats_check();
    vis_lines(5, 0, 170);
    blank_lines(3);
    frame_checks();

    // Abort after 100 lines; the next frame rewrites the same bank.
    vsync_lines(1);
    blank_lines(2);
    vis_lines(100, 1, 8);
    vsync_lines(0);
    frame_checks();
    blank_lines(2);
    vis_lines(3, 1, 30);
    en = 0;
    vis_lines(3, 1, 30);
    blank_lines(3);
    frame_checks();

    // Disabled frame, long enough to saturate the line counter; ENABLE returns mid-frame.
    vsync_lines(1);
    blank_lines(260);
    en = 1;
    blank_lines(260);
    frame_checks();

    // 262-line frame.
    vsync_lines(1);
    blank_lines(20);
    stats_check();
    vis_lines(30, 1, 20);
    blank_lines(209);
    frame_checks();

    // Reset in the middle of a captured line.
    vsync_lines(1);
    stats_check();
    blank_lines(2);
    vis_lines(3, 10, 40);
    applyStimulus(0, 0, 20, 0, 5);
    vis_lines(3, 10, 40);
    blank_lines(3);
    frame_checks();

    vsync_lines(1);
    blank_lines(2);
    vis_lines(5, 1, 40);
    blank_lines(3);
    frame_checks();
    vsync_lines(1);
    blank_lines(1);
    stats_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
